// File: rtl/trig_num_fifo.sv
// First-word-fall-through FIFO of {fill_type, trig_num} between the trigger manager and the command manager.
// It also flags a break in the trigger-number sequence and any write offered while the FIFO is full.
module trig_num_fifo #(
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_trig_num,
    input  logic [1:0]  s_fill_type,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [23:0] m_trig_num,
    output logic [1:0]  m_fill_type,
    output logic [8:0]  count,
    output logic        afull,
    output logic        seq_err,
    output logic        wr_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [25:0]   mem [DEPTH];
    logic [25:0]   head_reg;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [8:0]    count_reg, count_next;
    logic          s_ready_reg, m_valid_reg, afull_reg;
    logic          seq_err_reg, wr_drop_reg, armed_reg;
    logic [23:0]   last_num_reg;
    logic          wr_en, rd_en;

    // Handshakes qualify only with registered flags, so no input-to-output path exists.
    assign wr_en = s_valid && s_ready_reg;
    assign rd_en = m_ready && m_valid_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (wr_en) wr_ptr_next = wr_ptr_reg + AW'(1);
        if (rd_en) rd_ptr_next = rd_ptr_reg + AW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_next = count_reg + 9'd1;
            2'b01:   count_next = count_reg - 9'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            s_ready_reg  <= 1'b0;
            m_valid_reg  <= 1'b0;
            afull_reg    <= 1'b0;
            seq_err_reg  <= 1'b0;
            wr_drop_reg  <= 1'b0;
            armed_reg    <= 1'b0;
            last_num_reg <= '0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            s_ready_reg <= (count_next != 9'(DEPTH));
            m_valid_reg <= (count_next != 9'd0);
            afull_reg   <= (count_next >= 9'(AFULL_LVL));
            if (s_valid && !s_ready_reg)
                wr_drop_reg <= 1'b1;
            if (wr_en) begin
                // Sequence wraps naturally at 24 bits, so 0xFFFFFF -> 0x000000 is accepted.
                if (armed_reg && (s_trig_num != last_num_reg + 24'd1))
                    seq_err_reg <= 1'b1;
                last_num_reg <= s_trig_num;
                armed_reg    <= 1'b1;
            end
        end
    end

    // Head register is read one cycle ahead from the next read address; a write landing
    // on that address (empty FIFO, or one entry being replaced) is bypassed straight in.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg] <= {s_fill_type, s_trig_num};
        if (wr_en && (wr_ptr_reg == rd_ptr_next))
            head_reg <= {s_fill_type, s_trig_num};
        else
            head_reg <= mem[rd_ptr_next];
    end

    assign s_ready     = s_ready_reg;
    assign m_valid     = m_valid_reg;
    assign m_trig_num  = head_reg[23:0];
    assign m_fill_type = head_reg[25:24];
    assign count       = count_reg;
    assign afull       = afull_reg;
    assign seq_err     = seq_err_reg;
    assign wr_drop     = wr_drop_reg;

endmodule

// File: tb/tb_trig_num_fifo.sv
// Scoreboard bench for trig_num_fifo: drivers push expected entries, a negedge monitor pops
// and compares every consumed head entry; status outputs are checked against directed values.
module tb_trig_num_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic [23:0] s_trig_num, m_trig_num;
    logic [1:0]  s_fill_type, m_fill_type;
    logic [8:0]  count;
    logic        afull, seq_err, wr_drop;

    int          checks = 0;
    int          errors = 0;
    logic [25:0] exp_q[$];
    logic        prod_done;

    trig_num_fifo #(.DEPTH(16), .AFULL_LVL(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_trig_num  (s_trig_num),
        .s_fill_type (s_fill_type),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_trig_num  (m_trig_num),
        .m_fill_type (m_fill_type),
        .count       (count),
        .afull       (afull),
        .seq_err     (seq_err),
        .wr_drop     (wr_drop)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Monitor: a read happens at the coming posedge whenever m_valid && m_ready now.
    always @(negedge clk) begin
        if (!reset && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got trig=0x%06h fill=%0d expected no entry", m_trig_num, m_fill_type);
            end else begin
                logic [25:0] e;
                e = exp_q.pop_front();
                chk("rd_entry", 32'({m_fill_type, m_trig_num}), 32'(e));
                $display("RD trig=0x%06h fill=%0d", m_trig_num, m_fill_type);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Trigger-manager style write: only offers s_valid when s_ready is already high.
    task automatic wr(input logic [23:0] n, input logic [1:0] f);
        int i;
        for (i = 0; i < 200; i++) begin
            if (s_ready) break;
            tick();
        end
        if (i == 200) begin
            checks++;
            errors++;
            $display("FAIL wr_timeout: got s_ready=0 expected 1 within 200 cycles");
        end
        s_valid     = 1'b1;
        s_trig_num  = n;
        s_fill_type = f;
        exp_q.push_back({f, n});
        $display("WR trig=0x%06h fill=%0d", n, f);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        m_ready = 1'b1;
        for (i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        m_ready = 1'b0;
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("drain_count", 32'(count), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset       = 1'b1;
        s_valid     = 1'b0;
        m_ready     = 1'b0;
        s_trig_num  = '0;
        s_fill_type = '0;
        prod_done   = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_afull", 32'(afull), 32'd0);
        chk("rst_seq_err", 32'(seq_err), 32'd0);
        chk("rst_wr_drop", 32'(wr_drop), 32'd0);
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("s_ready_after_rst", 32'(s_ready), 32'd1);

        // Three writes then three reads, first-word-fall-through.
        wr(24'd1, 2'd0);
        chk("fwft_m_valid_1", 32'(m_valid), 32'd1);
        wr(24'd2, 2'd1);
        wr(24'd3, 2'd2);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_m_valid", 32'(m_valid), 32'd1);
        chk("t1_head", 32'(m_trig_num), 32'd1);
        chk("t1_head_fill", 32'(m_fill_type), 32'd0);
        m_ready = 1'b1;
        tick();
        tick();
        tick();
        m_ready = 1'b0;
        chk("t1_m_valid_end", 32'(m_valid), 32'd0);
        chk("t1_count_end", 32'(count), 32'd0);
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // Fill to full, watch afull, refuse a held write, then accept it after one read.
        for (int i = 0; i < 16; i++) begin
            wr(24'(4 + i), 2'(i % 4));
            if (i == 10) chk("afull_at_11", 32'(afull), 32'd0);
            if (i == 11) chk("afull_at_12", 32'(afull), 32'd1);
        end
        chk("full_s_ready", 32'(s_ready), 32'd0);
        chk("full_count", 32'(count), 32'd16);
        chk("full_afull", 32'(afull), 32'd1);
        s_valid     = 1'b1;
        s_trig_num  = 24'd20;
        s_fill_type = 2'd0;
        tick();
        chk("wr_drop_set", 32'(wr_drop), 32'd1);
        chk("full_count_held", 32'(count), 32'd16);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("s_ready_after_rd", 32'(s_ready), 32'd1);
        chk("count_after_rd", 32'(count), 32'd15);
        exp_q.push_back({2'd0, 24'd20});
        tick();
        s_valid = 1'b0;
        chk("held_wr_count", 32'(count), 32'd16);
        drain();
        chk("afull_clear", 32'(afull), 32'd0);
        chk("t2_seq_err", 32'(seq_err), 32'd0);

        // Steady state: count 5 with simultaneous read and write for 40 cycles.
        for (int i = 0; i < 5; i++) wr(24'(21 + i), 2'(i % 4));
        for (int i = 0; i < 40; i++) begin
            s_valid     = 1'b1;
            m_ready     = 1'b1;
            s_trig_num  = 24'(26 + i);
            s_fill_type = 2'(3 - (i % 4));
            exp_q.push_back({s_fill_type, s_trig_num});
            tick();
            chk("steady_count", 32'(count), 32'd5);
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("steady_seq_err", 32'(seq_err), 32'd0);
        drain();

        // Asynchronous reset between edges with 7 entries stored.
        for (int i = 0; i < 7; i++) wr(24'(66 + i), 2'd1);
        chk("pre_rst_count", 32'(count), 32'd7);
        #3;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_m_valid", 32'(m_valid), 32'd0);
        chk("async_s_ready", 32'(s_ready), 32'd0);
        chk("async_wr_drop", 32'(wr_drop), 32'd0);
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);
        wr(24'h000042, 2'd1);
        chk("post_rst_head", 32'(m_trig_num), 32'h42);
        chk("post_rst_m_valid", 32'(m_valid), 32'd1);
        chk("post_rst_seq_err", 32'(seq_err), 32'd0);
        drain();

        // Sequence check across the 24-bit wrap, then a real break.
        do_reset();
        wr(24'hFFFFFE, 2'd0);
        wr(24'hFFFFFF, 2'd1);
        wr(24'h000000, 2'd2);
        chk("wrap_seq_err", 32'(seq_err), 32'd0);
        wr(24'h000005, 2'd3);
        chk("break_seq_err", 32'(seq_err), 32'd1);
        drain();
        wr(24'h000006, 2'd0);
        drain();
        chk("sticky_seq_err", 32'(seq_err), 32'd1);

        // Trigger-manager model with random fill type and random m_ready.
        do_reset();
        fork
            begin
                for (int i = 0; i < 40; i++)
                    wr(24'(i + 1), 2'($urandom_range(0, 3)));
                prod_done = 1'b1;
            end
            begin
                for (int i = 0; i < 3000; i++) begin
                    if (prod_done && exp_q.size() == 0) break;
                    m_ready = ($urandom_range(0, 3) == 0);
                    tick();
                end
                m_ready = 1'b0;
            end
        join
        chk("rand_q_empty", 32'(exp_q.size()), 32'd0);
        chk("rand_count", 32'(count), 32'd0);
        chk("rand_wr_drop", 32'(wr_drop), 32'd0);
        chk("rand_seq_err", 32'(seq_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
